// File: rtl/rv32m_pkg.sv
// rtl/rv32m_pkg.sv - shared types and constants for the RV32M divide sequencer
package rv32m_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } div_state_e;

    localparam logic [31:0] DIV_OVF_DIVIDEND = 32'h8000_0000;
    localparam logic [31:0] DIV_ZERO_QUO     = '1;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one radix-2 restoring divide iteration (combinational)
//
// Ports:
//   rem       current partial remainder (always < divisor)
//   quo       quotient/dividend shift register; MSB is the next dividend bit
//   divisor   divisor magnitude
//   rem_next  partial remainder after the shift and trial subtraction
//   quo_next  quo shifted left with the new quotient bit in the LSB
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quo_next
);

    // One extra bit: the shifted remainder can reach 2*divisor-1, and the
    // top bit of the difference doubles as the trial-subtraction sign.
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    assign shifted  = {rem, quo[XLEN-1]};
    assign diff     = shifted - {1'b0, divisor};
    assign rem_next = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    assign quo_next = {quo[XLEN-2:0], ~diff[XLEN]};

endmodule

// File: rtl/rv32m_div_seq.sv
// rtl/rv32m_div_seq.sv - iterative DIV/DIVU/REM/REMU sequencer with tagged result
//
// Ports:
//   clk, rst            core clock, synchronous active-low reset
//   flush               abandons any in-flight operation
//   in_valid/in_ready   operation handshake (op, rs1, rs2, rd_in)
//   out_valid/out_ready result handshake (result, rd_out)
//   busy                high whenever not IDLE; pipeline stall
module rv32m_div_seq
    import rv32m_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [XLEN-1:0]  rs1,
    input  logic [XLEN-1:0]  rs2,
    input  logic [TAG_W-1:0] rd_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] rd_out,
    output logic             busy
);

    localparam int CW = $clog2(XLEN);

    div_state_e       state_q, state_d;
    logic [CW-1:0]    count_q;
    logic [XLEN-1:0]  rem_q, quo_q, divisor_q;
    logic             is_rem_q, qneg_q, rneg_q;
    logic [TAG_W-1:0] tag_q;
    logic [XLEN-1:0]  result_q;
    logic [TAG_W-1:0] rd_out_q;

    // Operand decode for the accept cycle
    div_op_e          op_e;
    logic             is_signed, a_neg, b_neg;
    logic             div_zero, sgn_ovf, special;
    logic [XLEN-1:0]  a_mag, b_mag, special_res;
    logic             accept;

    assign op_e      = div_op_e'(op);
    assign is_signed = (op_e == DIV) || (op_e == REM);
    assign a_neg     = is_signed & rs1[XLEN-1];
    assign b_neg     = is_signed & rs2[XLEN-1];
    assign a_mag     = a_neg ? -rs1 : rs1;
    assign b_mag     = b_neg ? -rs2 : rs2;
    assign div_zero  = (rs2 == '0);
    assign sgn_ovf   = is_signed && (rs1 == DIV_OVF_DIVIDEND) && (rs2 == '1);
    assign special   = div_zero || sgn_ovf;

    always_comb begin
        special_res = '0;
        if (op[1]) begin
            special_res = div_zero ? rs1 : '0;
        end else begin
            special_res = div_zero ? DIV_ZERO_QUO : DIV_OVF_DIVIDEND;
        end
    end

    // Iteration datapath and final sign fixup on the last step's outputs
    logic [XLEN-1:0] rem_next, quo_next, fixed_res;

    div_step #(.XLEN(XLEN)) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (divisor_q),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    assign fixed_res = is_rem_q ? (rneg_q ? -rem_next : rem_next)
                                : (qneg_q ? -quo_next : quo_next);

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && !flush) begin
                    accept  = 1'b1;
                    state_d = special ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (count_q == '0) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            is_rem_q  <= 1'b0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            tag_q     <= '0;
            result_q  <= '0;
            rd_out_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                is_rem_q  <= op[1];
                qneg_q    <= a_neg ^ b_neg;
                rneg_q    <= a_neg;
                tag_q     <= rd_in;
                quo_q     <= a_mag;
                rem_q     <= '0;
                divisor_q <= b_mag;
                count_q   <= CW'(XLEN - 1);
                if (special) begin
                    result_q <= special_res;
                    rd_out_q <= rd_in;
                end
            end else if (state_q == BUSY && !flush) begin
                rem_q <= rem_next;
                quo_q <= quo_next;
                if (count_q == '0) begin
                    result_q <= fixed_res;
                    rd_out_q <= tag_q;
                end else begin
                    count_q <= count_q - 1'b1;
                end
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign result    = result_q;
    assign rd_out    = rd_out_q;

endmodule

// File: tb/tb_rv32m_div_seq.sv
// tb/tb_rv32m_div_seq.sv - self-checking bench for rv32m_div_seq
module tb_rv32m_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [31:0] rs1, rs2;
    logic [4:0]  rd_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    rv32m_div_seq dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd_in     (rd_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .rd_out    (rd_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // RISC-V M-extension semantics in plain arithmetic
    function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        logic ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            2'b00:   return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
            2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'b10:   return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        if (b == 0) return 1;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one operation, checks latency/result/tag, holds in DONE, drains.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] t, input int hold);
        int lat;
        int w;
        logic [31:0] exp_res;
        logic [31:0] held;
        exp_res = ref_div(o, a, b);
        w = 0;
        while (!in_ready && w < 100) begin
            tick();
            w++;
        end
        if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
        op = o; rs1 = a; rs2 = b; rd_in = t; in_valid = 1'b1;
        tick();
        lat = 1;
        while (!out_valid && lat < 100) begin
            check("busy_while_running", 32'(busy), 32'd1);
            check("no_accept_while_busy", 32'(in_ready), 32'd0);
            in_valid = 1'($urandom_range(0, 1));
            rs1 = $urandom; rs2 = $urandom; rd_in = 5'($urandom); op = 2'($urandom);
            tick();
            lat++;
        end
        in_valid = 1'b0;
        check("latency", 32'(lat), 32'(ref_lat(o, a, b)));
        check("result", result, exp_res);
        check("rd_out", 32'(rd_out), 32'(t));
        check("busy_done", 32'(busy), 32'd1);
        held = result;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (i == hold - 1) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_result", result, held);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("drain_idle_ready", 32'(in_ready), 32'd1);
        check("drain_valid_low", 32'(out_valid), 32'd0);
        check("drain_busy_low", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [1:0]  o;
        logic [31:0] a, b;
        int          saw;
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; op = 2'b00;
        rs1 = '0; rs2 = '0; rd_in = '0; out_ready = 1'b0;
        repeat (3) tick();
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_rd_out", 32'(rd_out), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b1;
        tick();

        // out_ready outside DONE is ignored
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("idle_out_ready_ignored", 32'(out_valid), 32'd0);

        run_op(2'b01, 32'd100, 32'd7, 5'd5, 1);
        run_op(2'b10, 32'hFFFF_FF9C, 32'd7, 5'd1, 0);
        run_op(2'b00, 32'hFFFF_FF9C, 32'd7, 5'd2, 0);
        run_op(2'b00, 32'h1234_5678, 32'd0, 5'd3, 0);
        run_op(2'b11, 32'h1234_5678, 32'd0, 5'd4, 0);
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 0);
        run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 0);
        run_op(2'b00, 32'h7FFF_FFFF, 32'h8000_0000, 5'd9, 10);
        run_op(2'b11, 32'hFFFF_FFFF, 32'd1, 5'd31, 0);

        // Flush at BUSY cycle 10: abandoned, never completes
        op = 2'b01; rs1 = 32'd1000; rs2 = 32'd3; rd_in = 5'd10; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_idle_ready", 32'(in_ready), 32'd1);
        check("flush_busy_low", 32'(busy), 32'd0);
        saw = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) saw = 1;
            tick();
        end
        check("flush_no_result", 32'(saw), 32'd0);

        // Request on a flush cycle is dropped
        op = 2'b01; rs1 = 32'd8; rs2 = 32'd2; rd_in = 5'd11; in_valid = 1'b1; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        check("flush_drops_request", 32'(in_ready), 32'd1);

        // Reset mid-BUSY
        op = 2'b00; rs1 = 32'd5000; rs2 = 32'd7; rd_in = 5'd12; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_result", result, 32'd0);
        check("midreset_rd_out", 32'(rd_out), 32'd0);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_in_ready", 32'(in_ready), 32'd1);
        run_op(2'b01, 32'd9, 32'd3, 5'd13, 0);

        // Randomized operations with biased special cases
        for (int n = 0; n < 150; n++) begin
            o = 2'($urandom);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 20));
                3: b = -32'($urandom_range(1, 20));
                4: a = 32'($urandom_range(0, 1000));
                default: ;
            endcase
            run_op(o, a, b, 5'($urandom), int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rv32m_div_seq.md
Name: rv32m_div_seq

Overview:
Iterative sequencer for the RV32M divide/remainder instructions (DIV, DIVU, REM, REMU) in the rv32i_core execute stage. It accepts one operation per handshake and runs a radix-2 restoring divide over XLEN cycles. Special cases (divide-by-zero, signed overflow) are resolved in one cycle. It presents the result with a destination tag and drives a busy flag that the hazard unit uses to stall the pipeline.

Parameters:
XLEN, 32, operand/result width
TAG_W, 5, destination register tag width (rd index)

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-low (0 = reset, sampled on rising clk)
flush  in  1  pipeline flush; abandons any in-flight operation
in_valid  in  1  operation request from the ID/EX register
in_ready  out  1  sequencer can accept an operation
op  in  2  00=DIV, 01=DIVU, 10=REM, 11=REMU
rs1  in  XLEN  dividend
rs2  in  XLEN  divisor
rd_in  in  TAG_W  destination tag
out_valid  out  1  result available
out_ready  in  1  writeback consumes the result
result  out  XLEN  quotient or remainder, per op
rd_out  out  TAG_W  tag of the result
busy  out  1  high whenever state != IDLE; drives the pipeline stall

Behaviour:
- States: IDLE, BUSY, DONE. Reset (rst=0 at a clock edge) forces IDLE and clears the count. Reset values: out_valid=0, result=0, rd_out=0, busy=0, in_ready=1.
- Reset has priority over flush. Flush has priority over all other transitions: any state goes to IDLE on the next edge, out_valid=0, and any request present that cycle is not accepted.
- in_ready = (state==IDLE).
- Accept occurs on a cycle with in_valid && in_ready && !flush. On accept, latch op and rd_in, the magnitudes |rs1| and |rs2| (signed ops only; unsigned ops take raw values), the quotient sign, and the remainder sign.
- Quotient sign = rs1[XLEN-1]^rs2[XLEN-1] for DIV. Remainder sign = rs1[XLEN-1] for REM. Both are 0 for unsigned ops.
- Special cases, decided at accept, go IDLE→DONE, so out_valid rises 1 cycle after accept:
  - Divide-by-zero (rs2==0): quotient = all ones; remainder = rs1 unchanged.
  - Signed overflow (DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF): quotient = 0x80000000; remainder = 0.
- Normal path: IDLE→BUSY, count = XLEN-1.
  - Each BUSY cycle: shift {rem, quo} left by 1 (shifting in the next dividend bit), trial-subtract the divisor from rem, and set the quotient LSB when the difference is non-negative.
  - Exit to DONE when count==0; otherwise decrement count.
  - out_valid rises XLEN+1 = 33 cycles after accept.
- On entry to DONE: result = signed-corrected quotient (op[1]=0) or remainder (op[1]=1), computed with two's-complement negation when the sign bit is set. rd_out = latched tag.
- DONE holds result, rd_out and out_valid stable until out_ready=1, then goes to IDLE.
  - There is no same-cycle re-accept; the next accept is possible one cycle after the drain.
  - out_ready while not DONE is ignored.
- Inputs changing while BUSY or DONE have no effect.
- All arithmetic is XLEN-bit unsigned internally. The partial remainder is XLEN+1 bits so the trial subtraction sign is available.

Decomposition:
- Shared package rv32m_pkg: div_op_e enum (DIV, DIVU, REM, REMU), div_state_e (IDLE, BUSY, DONE), and constants DIV_OVF_DIVIDEND=32'h8000_0000 and DIV_ZERO_QUO='1.
- Optional sub-module div_step: combinational one-iteration shift/trial-subtract, for unit-level reuse. The FSM, counter and sign fixup stay in rv32m_div_seq.

Test Plan:
1. DIVU 100/7, rd=5 → out_valid exactly 33 cycles after accept; result=14; rd_out=5; busy high throughout.
2. REM −100 (0xFFFFFF9C) / 7 → result=0xFFFFFFFE (−2). DIV same operands → 0xFFFFFFF2 (−14).
3. DIV x/0 with rs1=0x12345678 → result=0xFFFFFFFF after 1 cycle. REMU x/0 → result=0x12345678.
4. DIV 0x80000000/0xFFFFFFFF → result=0x80000000 after 1 cycle. REM same operands → 0.
5. Hold out_ready=0 for 10 cycles in DONE → result and out_valid stable. Then out_ready=1 → IDLE next cycle, in_ready=1. in_valid held during BUSY → not accepted.
6. Assert flush at BUSY cycle 10 → IDLE next cycle, out_valid never rises. Repeat with rst=0 mid-BUSY → all outputs at reset values next cycle. Then a new DIVU 9/3 completes with result=3.
